// File: rtl/aes_state_array.sv
// AES state store: row/column read-write, streamed column load/unload,
// and a one-row-per-cycle ShiftRows / InvShiftRows engine operating in place.
module aes_state_array #(
  parameter int unsigned NROWS = 4,
  parameter int unsigned NCOLS = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 2
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         cmd_valid,
  output logic                                         cmd_ready,
  input  logic [2:0]                                   cmd_op,
  input  logic [IDX_W-1:0]                             cmd_idx,
  input  logic [W*((NROWS > NCOLS) ? NROWS : NCOLS)-1:0] cmd_data,
  input  logic                                         ld_valid,
  output logic                                         ld_ready,
  input  logic [NROWS*W-1:0]                           ld_data,
  output logic                                         un_valid,
  input  logic                                         un_ready,
  output logic [NROWS*W-1:0]                           un_data,
  input  logic [IDX_W-1:0]                             rd_idx,
  input  logic                                         rd_rc,
  output logic [W*((NROWS > NCOLS) ? NROWS : NCOLS)-1:0] rd_data,
  output logic                                         busy,
  output logic [NROWS*NCOLS*W-1:0]                     state_flat
);

  localparam int unsigned RP_W = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int unsigned CP_W = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  localparam logic [2:0] OP_WR_COL    = 3'd0;
  localparam logic [2:0] OP_WR_ROW    = 3'd1;
  localparam logic [2:0] OP_SHIFT     = 3'd2;
  localparam logic [2:0] OP_INV_SHIFT = 3'd3;
  localparam logic [2:0] OP_CLEAR     = 3'd4;
  localparam logic [2:0] OP_UNLOAD    = 3'd5;

  logic [1:0]      state, state_d;
  logic [W-1:0]    cells   [NROWS][NCOLS];
  logic [W-1:0]    cells_d [NROWS][NCOLS];
  logic [CP_W-1:0] ld_col, ld_col_d;
  logic [CP_W-1:0] un_col, un_col_d;
  logic [RP_W-1:0] row_ptr, row_ptr_d;
  logic            shift_inv, shift_inv_d;

  logic cmd_fire, ld_fire, un_fire;
  logic ld_last, un_last, row_last;

  assign cmd_ready = (state == S_IDLE);
  assign ld_ready  = (state == S_LOAD) | ((state == S_IDLE) & ~cmd_valid);
  assign un_valid  = (state == S_UNLOAD);
  assign busy      = (state != S_IDLE);

  assign cmd_fire = cmd_valid & cmd_ready;
  assign ld_fire  = ld_valid & ld_ready;
  assign un_fire  = un_valid & un_ready;

  assign ld_last  = (32'(ld_col) == NCOLS - 1);
  assign un_last  = (32'(un_col) == NCOLS - 1);
  assign row_last = (32'(row_ptr) == NROWS - 1);

  always_comb begin
    state_d     = state;
    cells_d     = cells;
    ld_col_d    = ld_col;
    un_col_d    = un_col;
    row_ptr_d   = row_ptr;
    shift_inv_d = shift_inv;

    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_WR_COL: begin
              for (int unsigned c = 0; c < NCOLS; c++) begin
                if (32'(cmd_idx) == c) begin
                  for (int unsigned r = 0; r < NROWS; r++)
                    cells_d[r][c] = cmd_data[(NROWS-1-r)*W +: W];
                end
              end
            end
            OP_WR_ROW: begin
              for (int unsigned r = 0; r < NROWS; r++) begin
                if (32'(cmd_idx) == r) begin
                  for (int unsigned c = 0; c < NCOLS; c++)
                    cells_d[r][c] = cmd_data[(NCOLS-1-c)*W +: W];
                end
              end
            end
            OP_CLEAR: begin
              for (int unsigned r = 0; r < NROWS; r++)
                for (int unsigned c = 0; c < NCOLS; c++)
                  cells_d[r][c] = '0;
            end
            OP_SHIFT, OP_INV_SHIFT: begin
              state_d     = S_SHIFT;
              row_ptr_d   = '0;
              shift_inv_d = (cmd_op == OP_INV_SHIFT);
            end
            OP_UNLOAD: begin
              state_d  = S_UNLOAD;
              un_col_d = '0;
            end
            default: ;
          endcase
        end else if (ld_fire) begin
          for (int unsigned r = 0; r < NROWS; r++)
            cells_d[r][0] = ld_data[(NROWS-1-r)*W +: W];
          if (NCOLS > 1) begin
            state_d  = S_LOAD;
            ld_col_d = CP_W'(1);
          end else begin
            ld_col_d = '0;
          end
        end
      end

      S_LOAD: begin
        if (ld_fire) begin
          for (int unsigned c = 0; c < NCOLS; c++) begin
            if (32'(ld_col) == c) begin
              for (int unsigned r = 0; r < NROWS; r++)
                cells_d[r][c] = ld_data[(NROWS-1-r)*W +: W];
            end
          end
          if (ld_last) begin
            state_d  = S_IDLE;
            ld_col_d = '0;
          end else begin
            ld_col_d = ld_col + CP_W'(1);
          end
        end
      end

      S_SHIFT: begin
        // Source columns are elaboration constants per row; row_ptr only picks the row.
        for (int unsigned r = 0; r < NROWS; r++) begin
          if (32'(row_ptr) == r) begin
            for (int unsigned c = 0; c < NCOLS; c++) begin
              if (shift_inv)
                cells_d[r][c] = cells[r][(c + NCOLS - (r % NCOLS)) % NCOLS];
              else
                cells_d[r][c] = cells[r][(c + (r % NCOLS)) % NCOLS];
            end
          end
        end
        if (row_last) begin
          state_d   = S_IDLE;
          row_ptr_d = '0;
        end else begin
          row_ptr_d = row_ptr + RP_W'(1);
        end
      end

      S_UNLOAD: begin
        if (un_fire) begin
          if (un_last) begin
            state_d  = S_IDLE;
            un_col_d = '0;
          end else begin
            un_col_d = un_col + CP_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ld_col    <= '0;
      un_col    <= '0;
      row_ptr   <= '0;
      shift_inv <= 1'b0;
      for (int unsigned r = 0; r < NROWS; r++)
        for (int unsigned c = 0; c < NCOLS; c++)
          cells[r][c] <= '0;
    end else begin
      state     <= state_d;
      ld_col    <= ld_col_d;
      un_col    <= un_col_d;
      row_ptr   <= row_ptr_d;
      shift_inv <= shift_inv_d;
      cells     <= cells_d;
    end
  end

  always_comb begin
    un_data = '0;
    for (int unsigned c = 0; c < NCOLS; c++) begin
      if (32'(un_col) == c) begin
        for (int unsigned r = 0; r < NROWS; r++)
          un_data[(NROWS-1-r)*W +: W] = cells[r][c];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_rc) begin
      for (int unsigned c = 0; c < NCOLS; c++) begin
        if (32'(rd_idx) == c) begin
          for (int unsigned r = 0; r < NROWS; r++)
            rd_data[(NROWS-1-r)*W +: W] = cells[r][c];
        end
      end
    end else begin
      for (int unsigned r = 0; r < NROWS; r++) begin
        if (32'(rd_idx) == r) begin
          for (int unsigned c = 0; c < NCOLS; c++)
            rd_data[(NCOLS-1-c)*W +: W] = cells[r][c];
        end
      end
    end
  end

  always_comb begin
    state_flat = '0;
    for (int unsigned c = 0; c < NCOLS; c++)
      for (int unsigned r = 0; r < NROWS; r++)
        state_flat[(NROWS*NCOLS-1-(c*NROWS+r))*W +: W] = cells[r][c];
  end

endmodule
